// File: rtl/mul8_sequencer.sv
// mul8_sequencer: upstream driver for the 8-bit multiplier stage.
// Takes operand pairs over a valid/accept handshake. Runs the multiplier's
// two-cycle register-write phases, then strobes the multiplier and waits for
// it to finish. The captured product is offered downstream over valid/taken.
// Optional feature: define MUL8_SEQ_TIMEOUT_EN to add a BUSY watchdog that
// sets the sticky tx_error flag and completes with a zero product.

module mul8_sequencer (
  input  logic        aclk,
  input  logic        areset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_a,
  input  logic [7:0]  rx_b,
  output logic        tx_accept,
  output logic        tx_mul_enable,
  output logic [1:0]  tx_mul_write,
  output logic [7:0]  tx_mul_operand,
  output logic        tx_mul_strobe,
  input  logic [15:0] rx_mul_result,
  input  logic        rx_mul_ready,
  output logic        tx_valid,
  output logic [15:0] tx_product,
  input  logic        rx_taken,
  output logic        tx_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_STROBE = 3'd4;
  localparam logic [2:0] S_BUSY   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // The multiplier registers enable/write internally, so each write phase
  // must hold its operand for two cycles: leave after phase count 1.
  localparam logic [1:0] PHASE_LAST = 2'd1;

  logic [2:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        seen_low_q, seen_low_d;
  logic [15:0] product_q, product_d;
  logic        enable_q, enable_d;

`ifdef MUL8_SEQ_TIMEOUT_EN
  // Count value on the 31st consecutive BUSY cycle without completion.
  localparam logic [4:0] WD_LAST = 5'd30;

  logic [4:0]  wd_q, wd_d;
  logic        error_q, error_d;
`endif

  // Next-state, operand latching, completion detection and product capture.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    seen_low_d = 1'b0;
    product_d  = product_q;
    enable_d   = 1'b1;
`ifdef MUL8_SEQ_TIMEOUT_EN
    wd_d       = 5'd0;
    error_d    = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_valid && enable_q) begin
          a_d     = rx_a;
          b_d     = rx_b;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (phase_q == PHASE_LAST) state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        if (phase_q == PHASE_LAST) state_d = S_SETTLE;
      end
      S_SETTLE: state_d = S_STROBE;
      S_STROBE: state_d = S_BUSY;
      S_BUSY: begin
        // Ready may still be high from the previous idle period; only a
        // low-then-high sequence seen inside BUSY means the product is done.
        seen_low_d = seen_low_q | ~rx_mul_ready;
        if (seen_low_q && rx_mul_ready) begin
          product_d = rx_mul_result;
          state_d   = S_DONE;
        end
`ifdef MUL8_SEQ_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          error_d   = 1'b1;
          product_d = 16'h0000;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q + 5'd1;
        end
`endif
      end
      S_DONE: begin
        if (rx_taken) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    phase_d = (state_d != state_q) ? 2'd0 : phase_q + 2'd1;
  end

  // State and datapath registers; reset drops any in-flight pair.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      phase_q    <= 2'd0;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      seen_low_q <= 1'b0;
      product_q  <= 16'h0000;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      a_q        <= a_d;
      b_q        <= b_d;
      seen_low_q <= seen_low_d;
      product_q  <= product_d;
      enable_q   <= enable_d;
    end
  end

`ifdef MUL8_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wd_q    <= 5'd0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign tx_error = error_q;
`else
  assign tx_error = 1'b0;
`endif

  // Multiplier bus and handshake outputs decoded from the current state.
  always_comb begin
    tx_accept      = 1'b0;
    tx_mul_write   = 2'b00;
    tx_mul_operand = 8'h00;
    tx_mul_strobe  = 1'b0;
    tx_valid       = 1'b0;
    case (state_q)
      S_IDLE:   tx_accept = enable_q;
      S_LOAD_A: begin
        tx_mul_write   = 2'b01;
        tx_mul_operand = a_q;
      end
      S_LOAD_B: begin
        tx_mul_write   = 2'b10;
        tx_mul_operand = b_q;
      end
      S_STROBE: tx_mul_strobe = 1'b1;
      S_DONE:   tx_valid = 1'b1;
      default: ;
    endcase
  end

  assign tx_mul_enable = enable_q;
  assign tx_product    = product_q;

endmodule

// File: tb/tb_mul8_sequencer.sv
// Testbench for mul8_sequencer with a behavioural pipelined multiplier model
// and a product scoreboard. Works with or without MUL8_SEQ_TIMEOUT_EN.

module tb_mul8_sequencer;

  logic        aclk;
  logic        areset;
  logic        rx_valid;
  logic [7:0]  rx_a;
  logic [7:0]  rx_b;
  logic        tx_accept;
  logic        tx_mul_enable;
  logic [1:0]  tx_mul_write;
  logic [7:0]  tx_mul_operand;
  logic        tx_mul_strobe;
  logic [15:0] rx_mul_result;
  logic        rx_mul_ready;
  logic        tx_valid;
  logic [15:0] tx_product;
  logic        rx_taken;
  logic        tx_error;

  int checks;
  int failures;
  int cyc;
  int abs_cyc;
  int accept_cyc;
  logic [15:0] exp_q[$];

  // Multiplier model state.
  logic        model_stuck;
  logic        mdl_en_r;
  logic [1:0]  mdl_w_r;
  logic [7:0]  mdl_op_r;
  logic [7:0]  mdl_reg0;
  logic [7:0]  mdl_reg1;
  logic [2:0]  mdl_busy;
  logic [15:0] mdl_result;

  mul8_sequencer dut (
    .aclk           (aclk),
    .areset         (areset),
    .rx_valid       (rx_valid),
    .rx_a           (rx_a),
    .rx_b           (rx_b),
    .tx_accept      (tx_accept),
    .tx_mul_enable  (tx_mul_enable),
    .tx_mul_write   (tx_mul_write),
    .tx_mul_operand (tx_mul_operand),
    .tx_mul_strobe  (tx_mul_strobe),
    .rx_mul_result  (rx_mul_result),
    .rx_mul_ready   (rx_mul_ready),
    .tx_valid       (tx_valid),
    .tx_product     (tx_product),
    .rx_taken       (rx_taken),
    .tx_error       (tx_error)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Multiplier model: registered enable/write, four busy cycles per product.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mdl_en_r   <= 1'b0;
      mdl_w_r    <= 2'b00;
      mdl_op_r   <= 8'h00;
      mdl_reg0   <= 8'h00;
      mdl_reg1   <= 8'h00;
      mdl_busy   <= 3'd0;
      mdl_result <= 16'h0000;
    end else begin
      mdl_en_r <= tx_mul_enable;
      mdl_w_r  <= tx_mul_write;
      mdl_op_r <= tx_mul_operand;
      if (mdl_en_r && mdl_w_r[0]) mdl_reg0 <= mdl_op_r;
      if (mdl_en_r && mdl_w_r[1]) mdl_reg1 <= mdl_op_r;
      if (tx_mul_strobe && !model_stuck) begin
        mdl_busy   <= 3'd4;
        mdl_result <= {8'h00, mdl_reg0} * {8'h00, mdl_reg1};
      end else if (mdl_busy != 3'd0) begin
        mdl_busy <= mdl_busy - 3'd1;
      end
    end
  end

  assign rx_mul_ready  = (mdl_busy == 3'd0);
  assign rx_mul_result = mdl_result;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; a product handshake in the ending cycle is scored.
  task automatic tick();
    if (tx_valid && rx_taken) begin
      if (exp_q.size() > 0) begin
        checkOutput("sb_product", 32'(tx_product), 32'(exp_q.pop_front()));
      end else begin
        checkOutput("sb_unexpected_output", 32'(exp_q.size()), 32'd1);
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
    abs_cyc++;
  endtask

  // Present a pair, wait (bounded) for acceptance, and score its product.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    int waited;
    rx_valid = 1'b1;
    rx_a     = a;
    rx_b     = b;
    waited   = 0;
    while (!tx_accept && waited < 40) begin
      tick();
      waited++;
    end
    checkOutput("accept_seen", 32'(tx_accept), 32'd1);
    accept_cyc = abs_cyc;
    cyc = 0;
    exp_q.push_back({8'h00, a} * {8'h00, b});
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic waitValid(input int budget);
    while (!tx_valid && cyc < budget) tick();
  endtask

  task automatic doReset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    tick();
  endtask

  initial begin
    logic [1:0] exp_w[6];
    logic [7:0] exp_op[6];
    logic       exp_st[6];
    int first_accept;
    logic seen_valid;

    checks = 0; failures = 0; cyc = 0; abs_cyc = 0; accept_cyc = 0;
    areset = 1'b1; rx_valid = 1'b0; rx_a = 8'h00; rx_b = 8'h00;
    rx_taken = 1'b0; model_stuck = 1'b0;

    // Reset values while reset is held.
    tick(); tick(); tick();
    checkOutput("rst_accept",  32'(tx_accept), 32'd0);
    checkOutput("rst_enable",  32'(tx_mul_enable), 32'd0);
    checkOutput("rst_write",   32'(tx_mul_write), 32'd0);
    checkOutput("rst_operand", 32'(tx_mul_operand), 32'd0);
    checkOutput("rst_strobe",  32'(tx_mul_strobe), 32'd0);
    checkOutput("rst_valid",   32'(tx_valid), 32'd0);
    checkOutput("rst_product", 32'(tx_product), 32'd0);
    checkOutput("rst_error",   32'(tx_error), 32'd0);
    areset = 1'b0;
    tick();
    checkOutput("post_rst_enable", 32'(tx_mul_enable), 32'd1);
    checkOutput("post_rst_accept", 32'(tx_accept), 32'd1);

    // Single multiply 3*5 with write/operand sequence and latency.
    $display("[TB] single multiply 3*5");
    exp_w  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
    exp_op = '{8'h03, 8'h03, 8'h05, 8'h05, 8'h00, 8'h00};
    exp_st = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(8'd3, 8'd5);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("seq_write_c%0d", k + 1), 32'(tx_mul_write), 32'(exp_w[k]));
      checkOutput($sformatf("seq_operand_c%0d", k + 1), 32'(tx_mul_operand), 32'(exp_op[k]));
      checkOutput($sformatf("seq_strobe_c%0d", k + 1), 32'(tx_mul_strobe), 32'(exp_st[k]));
      tick();
    end
    waitValid(30);
    checkOutput("lat_valid_cycle", 32'(cyc), 32'd12);

    // Downstream stall for five cycles.
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_valid",   32'(tx_valid), 32'd1);
      checkOutput("stall_product", 32'(tx_product), 32'h000F);
      checkOutput("stall_accept",  32'(tx_accept), 32'd0);
      tick();
    end
    rx_taken = 1'b1;
    tick();
    rx_taken = 1'b0;
    checkOutput("after_taken_accept", 32'(tx_accept), 32'd1);
    checkOutput("after_taken_valid",  32'(tx_valid), 32'd0);
    checkOutput("hold_product",       32'(tx_product), 32'h000F);
    checkOutput("normal_error",       32'(tx_error), 32'd0);

    // Back-to-back pairs with rx_taken tied high.
    $display("[TB] back-to-back 2*7 then 4*4");
    rx_taken = 1'b1;
    applyStimulus(8'd2, 8'd7);
    first_accept = accept_cyc;
    applyStimulus(8'd4, 8'd4);
    checkOutput("b2b_spacing", 32'(accept_cyc - first_accept), 32'd13);
    waitValid(30);
    checkOutput("b2b_lat", 32'(cyc), 32'd12);
    checkOutput("b2b_product2", 32'(tx_product), 32'h0010);
    tick();
    rx_taken = 1'b0;

    // Reset in the middle of LOAD_B.
    $display("[TB] reset during LOAD_B");
    applyStimulus(8'd9, 8'd9);
    tick(); tick();
    checkOutput("midrst_in_loadb", 32'(tx_mul_write), 32'd2);
    areset = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("midrst_write",   32'(tx_mul_write), 32'd0);
    checkOutput("midrst_operand", 32'(tx_mul_operand), 32'd0);
    checkOutput("midrst_enable",  32'(tx_mul_enable), 32'd0);
    checkOutput("midrst_accept",  32'(tx_accept), 32'd0);
    tick();
    checkOutput("midrst_next_write", 32'(tx_mul_write), 32'd0);
    checkOutput("midrst_next_valid", 32'(tx_valid), 32'd0);
    areset = 1'b0;
    tick();
    applyStimulus(8'd1, 8'd1);
    waitValid(30);
    checkOutput("midrst_lat", 32'(cyc), 32'd12);
    rx_taken = 1'b1;
    tick();
    rx_taken = 1'b0;

    // rx_valid pulsed during BUSY/DONE must not disturb the pending pair.
    $display("[TB] rx_valid during BUSY/DONE");
    applyStimulus(8'd6, 8'd9);
    while (cyc < 8) tick();
    rx_valid = 1'b1; rx_a = 8'hFF; rx_b = 8'hFF;
    while (!tx_valid && cyc < 30) begin
      checkOutput("busy_accept_low", 32'(tx_accept), 32'd0);
      tick();
    end
    checkOutput("busy_lat", 32'(cyc), 32'd12);
    for (int k = 0; k < 2; k++) begin
      checkOutput("done_accept_low", 32'(tx_accept), 32'd0);
      checkOutput("done_product", 32'(tx_product), 32'h0036);
      tick();
    end
    rx_valid = 1'b0;
    rx_taken = 1'b1;
    tick();
    rx_taken = 1'b0;
    checkOutput("busy_back_idle", 32'(tx_accept), 32'd1);

    // Stuck-ready multiplier.
    $display("[TB] stuck multiplier ready");
    model_stuck = 1'b1;
    applyStimulus(8'd7, 8'd7);
`ifdef MUL8_SEQ_TIMEOUT_EN
    void'(exp_q.pop_back());
    exp_q.push_back(16'h0000);
    waitValid(60);
    checkOutput("timeout_cycle",   32'(cyc), 32'd38);
    checkOutput("timeout_error",   32'(tx_error), 32'd1);
    checkOutput("timeout_product", 32'(tx_product), 32'h0000);
    rx_taken = 1'b1;
    tick();
    rx_taken = 1'b0;
    checkOutput("timeout_sticky", 32'(tx_error), 32'd1);
    checkOutput("timeout_idle",   32'(tx_accept), 32'd1);
`else
    seen_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (tx_valid) seen_valid = 1'b1;
      tick();
    end
    checkOutput("stuck_no_valid", 32'(seen_valid), 32'd0);
    exp_q.delete();
`endif
    model_stuck = 1'b0;
    doReset();
    checkOutput("final_error_clear", 32'(tx_error), 32'd0);
    checkOutput("final_accept",      32'(tx_accept), 32'd1);
    checkOutput("sb_drained",        32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
